// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg
// Shared widths, defaults and the fetch state type for the instruction-fetch
// front end (if_fetch_queue and its queue sub-module).
//   DEF_A_WIDTH / DEF_D_WIDTH : default PC and instruction word widths
//   DEF_DEPTH                 : default queue depth (also the request credit cap)
//   DEF_RESET_PC              : default fetch PC after reset
//   INSTR_BYTES               : bytes per instruction word (PC step)
//   fetch_state_e             : FETCH (nothing to drop) / FLUSH (dropping stale responses)
package if_fetch_queue_pkg;

  localparam int          DEF_A_WIDTH  = 32;
  localparam int          DEF_D_WIDTH  = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// if_fetch_queue_fifo
// Synchronous FIFO holding {pc, instr} entries for the fetch front end.
// The head is read straight out of registered storage, so a push becomes
// visible at the head one cycle later. A flush empties it in one cycle.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-low reset
//   flush         : discard all entries (wins over push/pop)
//   push/push_data: write one entry
//   pop           : remove the head entry
//   head_valid    : FIFO is not empty
//   head_data     : head entry, forced to 0 while empty
//   count         : number of stored entries
module if_fetch_queue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Storage needs no reset: reads are masked by head_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch front end. Owns the fetch PC, issues in-order word reads
// to instruction memory, queues returned words with their PCs and hands
// {pc, instr} to decode over a valid/ready handshake. A redirect restarts
// fetch at a new PC, clears the queue and drops every in-flight response.
// Ports:
//   clk, rst                 : rising-edge clock, asynchronous active-low reset
//   imem_req_valid/ready/addr: read request channel (word-aligned address)
//   imem_rsp_valid/data      : in-order read responses
//   redirect_valid/pc        : one-cycle restart pulse and target (bits [1:0] ignored)
//   out_valid/ready          : decode handshake
//   out_instr/out_pc         : queue head, 0 while empty
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                 A_WIDTH  = DEF_A_WIDTH,
  parameter int                 D_WIDTH  = DEF_D_WIDTH,
  parameter int                 DEPTH    = DEF_DEPTH,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc
);

  localparam int                 CW      = $clog2(DEPTH + 1);
  localparam logic [A_WIDTH-1:0] PC_STEP = A_WIDTH'(INSTR_BYTES);

  logic [A_WIDTH-1:0]         fetch_pc;
  logic [A_WIDTH-1:0]         rsp_pc;
  logic [A_WIDTH-1:0]         redirect_target;
  logic [CW-1:0]              outst;
  logic [CW-1:0]              drop_cnt;
  logic [CW-1:0]              drop_cnt_next;
  logic [CW-1:0]              count;
  logic [CW:0]                in_use;
  logic [A_WIDTH+D_WIDTH-1:0] head_data;
  fetch_state_e               state;
  fetch_state_e               state_next;
  logic                       rsp_fire;
  logic                       req_fire;
  logic                       pop;
  logic                       push;
  logic                       drop_rsp;
  logic                       unused_pc_bits;

  assign redirect_target = {redirect_pc[A_WIDTH-1:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc[1:0];

  // Responses with nothing outstanding are ignored (and flagged below).
  assign rsp_fire = imem_rsp_valid && (outst != '0);

  // Credit rule: queued + outstanding never exceeds DEPTH, so every accepted
  // response is guaranteed a free queue slot.
  assign in_use         = {1'b0, count} + {1'b0, outst};
  assign imem_req_valid = rst && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign pop  = out_valid && out_ready;
  // A response landing in the redirect cycle belongs to the old stream.
  assign push = rsp_fire && !drop_rsp && !redirect_valid;

  // PC tracking and outstanding-request count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (push)     rsp_pc   <= rsp_pc + PC_STEP;
      end
    end
  end

  // Flush state register: FLUSH exactly while stale responses remain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // A redirect re-latches the drop count with everything still in flight,
  // minus a response consumed in that same cycle.
  always_comb begin
    drop_cnt_next = drop_cnt;
    if (redirect_valid) begin
      drop_cnt_next = outst - CW'(rsp_fire);
    end else if (rsp_fire && (state == FLUSH)) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end
    state_next = (drop_cnt_next != '0) ? FLUSH : FETCH;
  end

  always_comb begin
    drop_rsp = (state == FLUSH);
  end

  if_fetch_queue_fifo #(
    .WIDTH (A_WIDTH + D_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({rsp_pc, imem_rsp_data}),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign out_pc    = head_data[A_WIDTH+D_WIDTH-1:D_WIDTH];
  assign out_instr = head_data[D_WIDTH-1:0];

  rsp_without_request : assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outst != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
// Self-checking bench for if_fetch_queue. The bench plays instruction memory
// (in-order responses with a configurable latency) and decode. A reference
// model tracks the expected decode stream as a queue of {pc, instr}, tagging
// each request with a stream epoch so that anything issued before a redirect
// or reset never reaches decode.
module tb_if_fetch_queue;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  if_fetch_queue #(
    .A_WIDTH  (AW),
    .D_WIDTH  (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  req_t          mem_q[$];
  ent_t          out_q[$];
  logic [AW-1:0] m_fetch_pc;
  int            epoch;
  int            cyc = 0;
  int            vectors;
  int            miscompares;

  int            p_req_ready = 100;
  int            p_out_ready = 100;
  int            p_redirect  = 0;
  int            lat_min     = 1;
  int            lat_max     = 1;
  bit            redir_pending = 1'b0;
  logic [AW-1:0] redir_target  = '0;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive every DUT input shortly after each rising edge.
  task automatic apply_stimulus();
    imem_req_ready = (int'($urandom_range(99)) < p_req_ready);
    out_ready      = (int'($urandom_range(99)) < p_out_ready);
    if (redir_pending) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_pending  = 1'b0;
    end else if (rst && (int'($urandom_range(99)) < p_redirect)) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    apply_stimulus();
  end

  // Compare the DUT against the model, then advance the model across the
  // coming rising edge using the handshakes visible now.
  always @(negedge clk) begin
    bit   exp_req;
    int   lat;
    req_t r;
    if (!rst) begin
      check_output("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      check_output("rst_out_pc", 64'(out_pc), 64'd0);
      check_output("rst_out_instr", 64'(out_instr), 64'd0);
      out_q.delete();
      m_fetch_pc = RESET_PC;
      epoch++;
      if (imem_rsp_valid && (mem_q.size() > 0)) void'(mem_q.pop_front());
    end else begin
      exp_req = !redirect_valid && ((out_q.size() + mem_q.size()) < DEPTH);
      check_output("out_valid", 64'(out_valid), 64'(out_q.size() > 0));
      if (out_q.size() > 0) begin
        check_output("out_pc", 64'(out_pc), 64'(out_q[0].pc));
        check_output("out_instr", 64'(out_instr), 64'(out_q[0].instr));
      end else begin
        check_output("idle_out_pc", 64'(out_pc), 64'd0);
        check_output("idle_out_instr", 64'(out_instr), 64'd0);
      end
      check_output("req_valid", 64'(imem_req_valid), 64'(exp_req));
      if (exp_req) check_output("req_addr", 64'(imem_req_addr), 64'(m_fetch_pc));

      if ((out_q.size() > 0) && out_ready) void'(out_q.pop_front());
      if (imem_rsp_valid && (mem_q.size() > 0)) begin
        r = mem_q.pop_front();
        if ((r.epoch == epoch) && !redirect_valid)
          out_q.push_back('{pc: r.addr, instr: word_at(r.addr)});
      end
      if (exp_req && imem_req_ready) begin
        lat = lat_min + int'($urandom_range(lat_max - lat_min));
        mem_q.push_back('{addr: m_fetch_pc, epoch: epoch, due: cyc + lat});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        out_q.delete();
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
        epoch++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_knobs(input int req_p, input int out_p, input int lmin, input int lmax, input int redir_p);
    p_req_ready = req_p;
    p_out_ready = out_p;
    lat_min     = lmin;
    lat_max     = lmax;
    p_redirect  = redir_p;
  endtask

  // Hold reset until memory has returned everything still in flight, then
  // release just after a rising edge so the model sees the first live edge.
  task automatic hold_and_release();
    bit drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      step();
      drained = (i >= 2) && (mem_q.size() == 0);
    end
    check_output("reset_drain_timeout", 64'(drained), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    hold_and_release();
  endtask

  task automatic wait_out_valid(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      seen = out_valid;
    end
    check_output({name, "_timeout"}, 64'(seen), 64'd1);
  endtask

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    vectors        = 0;
    miscompares    = 0;
    epoch          = 0;
    m_fetch_pc     = RESET_PC;

    // Streaming with single-cycle memory: one instruction per cycle.
    set_knobs(100, 100, 1, 1, 0);
    hold_and_release();
    step();
    check_output("t1_first_addr", 64'(imem_req_addr), 64'h0);
    check_output("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
    wait_out_valid("t1", 10);
    check_output("t1_pc0", 64'(out_pc), 64'h0);
    check_output("t1_instr0", 64'(out_instr), 64'h5A5A_EDCB);
    step();
    check_output("t1_pc1", 64'(out_pc), 64'h4);
    check_output("t1_instr1", 64'(out_instr), 64'h5A5E_EDCB);
    step();
    check_output("t1_pc2", 64'(out_pc), 64'h8);
    repeat (30) step();

    // Decode stalled: the credit cap stops requests with four words queued.
    set_knobs(100, 0, 1, 1, 0);
    do_reset();
    repeat (20) step();
    check_output("t2_out_valid", 64'(out_valid), 64'd1);
    check_output("t2_head_pc", 64'(out_pc), 64'h0);
    check_output("t2_req_valid", 64'(imem_req_valid), 64'd0);
    check_output("t2_req_addr", 64'(imem_req_addr), 64'h10);
    p_out_ready = 100;
    repeat (20) step();

    // Redirect with two requests in flight on a three-cycle memory.
    set_knobs(100, 100, 3, 3, 0);
    do_reset();
    step();
    step();
    redir_target  = 32'h0000_0103;
    redir_pending = 1'b1;
    step();
    check_output("t3_redirect_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    check_output("t3_new_req_valid", 64'(imem_req_valid), 64'd1);
    check_output("t3_new_req_addr", 64'(imem_req_addr), 64'h100);
    wait_out_valid("t3", 20);
    check_output("t3_pc", 64'(out_pc), 64'h100);
    check_output("t3_instr", 64'(out_instr), 64'h5B5A_EDCB);
    repeat (10) step();

    // Memory not ready: request and address hold, then exactly one accept.
    set_knobs(100, 100, 1, 1, 0);
    do_reset();
    step();
    step();
    p_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("t4_hold_valid", 64'(imem_req_valid), 64'd1);
      check_output("t4_hold_addr", 64'(imem_req_addr), 64'h8);
    end
    p_req_ready = 100;
    step();
    p_req_ready = 0;
    check_output("t4_pre_accept_addr", 64'(imem_req_addr), 64'h8);
    step();
    check_output("t4_after_accept_addr", 64'(imem_req_addr), 64'hC);
    check_output("t4_after_accept_valid", 64'(imem_req_valid), 64'd1);
    step();
    check_output("t4_single_accept_addr", 64'(imem_req_addr), 64'hC);
    p_req_ready = 100;
    repeat (10) step();

    // Redirect coinciding with a response and a decode pop.
    set_knobs(100, 100, 2, 2, 0);
    do_reset();
    repeat (10) step();
    redir_target  = 32'h2000_0046;
    redir_pending = 1'b1;
    step();
    check_output("t5_pop_valid", 64'(out_valid), 64'd1);
    step();
    check_output("t5_cleared", 64'(out_valid), 64'd0);
    wait_out_valid("t5", 20);
    check_output("t5_pc", 64'(out_pc), 64'h2000_0044);
    check_output("t5_instr", 64'(out_instr), 64'h5A1E_CDCB);
    repeat (10) step();

    // Reset in the middle of a burst with three requests outstanding.
    set_knobs(100, 100, 3, 3, 0);
    do_reset();
    repeat (6) step();
    check_output("t6_busy", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_output("t6_req_valid", 64'(imem_req_valid), 64'd0);
    check_output("t6_out_valid", 64'(out_valid), 64'd0);
    check_output("t6_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    check_output("t6_out_pc", 64'(out_pc), 64'h0);
    check_output("t6_out_instr", 64'(out_instr), 64'h0);
    hold_and_release();
    step();
    check_output("t6_restart_addr", 64'(imem_req_addr), 64'(RESET_PC));
    wait_out_valid("t6", 20);
    check_output("t6_restart_pc", 64'(out_pc), 64'(RESET_PC));
    repeat (10) step();

    // Randomized traffic with random stalls, latencies and redirects.
    set_knobs(75, 60, 1, 4, 4);
    repeat (3000) step();
    set_knobs(50, 20, 1, 3, 2);
    repeat (1500) step();
    set_knobs(100, 100, 1, 1, 0);
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
